// File: rtl/pe_pkg.sv
// Shared types and widths for the PE feed path: operand/accumulator widths,
// dataflow encoding, per-beat control bundle and sequencer states.
package pe_pkg;

    localparam int A_W     = 8;
    localparam int ACC_W   = 20;
    localparam int ID_W    = 3;
    localparam int SHIFT_W = 5;

    typedef enum logic {
        DF_OS = 1'b0,
        DF_WS = 1'b1
    } dataflow_t;

    typedef struct packed {
        dataflow_t            dataflow;
        logic                 propagate;
        logic [SHIFT_W-1:0]   shift;
        logic [ID_W-1:0]      id;
        logic                 last;
    } pe_ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        PRELOAD,
        COMPUTE
    } seq_state_t;

endpackage

// File: rtl/pe_inflight_counter.sv
// Saturating up/down counter of commands in flight; flags a decrement that
// arrives while the count is already zero.
module pe_inflight_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         underflow
);

    localparam logic [W-1:0] MAX_CNT = W'(MAX);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        count_d   = count_q;
        underflow = 1'b0;
        unique case ({inc, dec})
            2'b10: if (count_q != MAX_CNT) count_d = count_q + 1'b1;
            2'b01: begin
                if (count_q == '0) underflow = 1'b1;
                else               count_d   = count_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: state uses non-blocking assignments so all flops update together on the edge.
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pe_feed_sequencer.sv
// Sequences one matmul command into a systolic PE: optional preload beat, then
// compute beats tagged with id/last and an alternating propagate flag.
module pe_feed_sequencer
    import pe_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_dataflow,
    input  logic [SHIFT_W-1:0]            cmd_shift,
    input  logic [ID_W-1:0]               cmd_id,
    input  logic [LEN_W-1:0]              cmd_len,
    input  logic                          cmd_preload,
    input  logic [ACC_W-1:0]              cmd_d,

    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic [A_W-1:0]                data_a,
    input  logic [ACC_W-1:0]              data_b,

    output logic                          pe_in_valid,
    output logic [A_W-1:0]                pe_in_a,
    output logic [ACC_W-1:0]              pe_in_b,
    output logic [ACC_W-1:0]              pe_in_d,
    output logic                          pe_in_control_dataflow,
    output logic                          pe_in_control_propagate,
    output logic [SHIFT_W-1:0]            pe_in_control_shift,
    output logic [ID_W-1:0]               pe_in_id,
    output logic                          pe_in_last,

    input  logic                          pe_out_valid,
    input  logic [ACC_W-1:0]              pe_out_c,
    input  logic [ID_W-1:0]               pe_out_id,
    input  logic                          pe_out_last,
    input  logic                          pe_bad_dataflow,

    output logic                          resp_valid,
    output logic [ACC_W-1:0]              resp_c,
    output logic [ID_W-1:0]               resp_id,
    output logic                          resp_last,

    output logic [$clog2(MAX_OUT+1)-1:0]  outstanding,
    input  logic                          err_clear,
    output logic [2:0]                    err_status
);

    localparam int              CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    seq_state_t          state_q, state_d;
    logic                prop_q, prop_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ACC_W-1:0]    dval_q, dval_d;
    dataflow_t           df_q, df_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic [ID_W-1:0]     id_q, id_d;

    logic                pe_valid_q, pe_valid_d;
    logic [A_W-1:0]      pe_a_q, pe_a_d;
    logic [ACC_W-1:0]    pe_b_q, pe_b_d;
    logic [ACC_W-1:0]    pe_d_q, pe_d_d;
    pe_ctrl_t            pe_ctrl_q, pe_ctrl_d;

    logic                resp_valid_q, resp_valid_d;
    logic [ACC_W-1:0]    resp_c_q, resp_c_d;
    logic [ID_W-1:0]     resp_id_q, resp_id_d;
    logic                resp_last_q, resp_last_d;

    logic [2:0]          err_q, err_d;

    logic                accept;
    logic                inc;
    logic                zero_len;
    logic                beat_last;
    logic                underflow;

    pe_inflight_counter #(
        .MAX (MAX_OUT),
        .W   (CNT_W)
    ) u_inflight (
        .clock     (clock),
        .reset_n   (reset_n),
        .inc       (inc),
        .dec       (pe_out_valid && pe_out_last),
        .count     (outstanding),
        .underflow (underflow)
    );

    always_comb begin
        state_d    = state_q;
        prop_d     = prop_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        dval_d     = dval_q;
        df_d       = df_q;
        shift_d    = shift_q;
        id_d       = id_q;
        pe_valid_d = 1'b0;
        pe_a_d     = pe_a_q;
        pe_b_d     = pe_b_q;
        pe_d_d     = pe_d_q;
        pe_ctrl_d  = pe_ctrl_q;
        cmd_ready  = 1'b0;
        data_ready = 1'b0;
        accept     = 1'b0;
        inc        = 1'b0;
        zero_len   = 1'b0;
        beat_last  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = (outstanding < MAX_CNT);
                accept    = cmd_valid && cmd_ready;
                if (accept) begin
                    df_d    = dataflow_t'(cmd_dataflow);
                    shift_d = cmd_shift;
                    id_d    = cmd_id;
                    len_d   = cmd_len;
                    dval_d  = cmd_d;
                    prop_d  = ~prop_q;
                    cnt_d   = '0;
                    // A zero-length command is flagged and dropped without touching the count.
                    if (cmd_len == '0) begin
                        zero_len = 1'b1;
                    end else begin
                        inc     = 1'b1;
                        state_d = cmd_preload ? PRELOAD : COMPUTE;
                    end
                end
            end
            PRELOAD: begin
                pe_valid_d = 1'b1;
                pe_a_d     = '0;
                pe_b_d     = '0;
                pe_d_d     = dval_q;
                pe_ctrl_d  = '{dataflow: df_q, propagate: prop_q, shift: shift_q,
                               id: id_q, last: 1'b0};
                state_d    = COMPUTE;
            end
            COMPUTE: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    beat_last  = (cnt_q == len_q - 1'b1);
                    pe_valid_d = 1'b1;
                    pe_a_d     = data_a;
                    pe_b_d     = data_b;
                    pe_d_d     = '0;
                    pe_ctrl_d  = '{dataflow: df_q, propagate: prop_q, shift: shift_q,
                                   id: id_q, last: beat_last};
                    if (beat_last) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        resp_valid_d = pe_out_valid;
        resp_c_d     = pe_out_c;
        resp_id_d    = pe_out_id;
        resp_last_d  = pe_out_last;
        // Set events are OR-ed in after the clear so they win in the same cycle.
        err_d = (err_clear ? 3'b000 : err_q) | {underflow, zero_len, pe_bad_dataflow};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            prop_q       <= 1'b0;
            cnt_q        <= '0;
            len_q        <= '0;
            dval_q       <= '0;
            df_q         <= DF_OS;
            shift_q      <= '0;
            id_q         <= '0;
            pe_valid_q   <= 1'b0;
            pe_a_q       <= '0;
            pe_b_q       <= '0;
            pe_d_q       <= '0;
            pe_ctrl_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_c_q     <= '0;
            resp_id_q    <= '0;
            resp_last_q  <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            prop_q       <= prop_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            dval_q       <= dval_d;
            df_q         <= df_d;
            shift_q      <= shift_d;
            id_q         <= id_d;
            pe_valid_q   <= pe_valid_d;
            pe_a_q       <= pe_a_d;
            pe_b_q       <= pe_b_d;
            pe_d_q       <= pe_d_d;
            pe_ctrl_q    <= pe_ctrl_d;
            resp_valid_q <= resp_valid_d;
            resp_c_q     <= resp_c_d;
            resp_id_q    <= resp_id_d;
            resp_last_q  <= resp_last_d;
            err_q        <= err_d;
        end
    end

    assign pe_in_valid             = pe_valid_q;
    assign pe_in_a                 = pe_a_q;
    assign pe_in_b                 = pe_b_q;
    assign pe_in_d                 = pe_d_q;
    assign pe_in_control_dataflow  = pe_ctrl_q.dataflow;
    assign pe_in_control_propagate = pe_ctrl_q.propagate;
    assign pe_in_control_shift     = pe_ctrl_q.shift;
    assign pe_in_id                = pe_ctrl_q.id;
    assign pe_in_last              = pe_ctrl_q.last;

    assign resp_valid = resp_valid_q;
    assign resp_c     = resp_c_q;
    assign resp_id    = resp_id_q;
    assign resp_last  = resp_last_q;
    assign err_status = err_q;

endmodule

// File: tb/tb_pe_feed_sequencer.sv
// Directed bench for pe_feed_sequencer: hand-computed expectations for beat
// sequencing, propagate toggling, in-flight limit, error flags and reset.
module tb_pe_feed_sequencer;

    logic        clock;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dataflow;
    logic [4:0]  cmd_shift;
    logic [2:0]  cmd_id;
    logic [7:0]  cmd_len;
    logic        cmd_preload;
    logic [19:0] cmd_d;
    logic        data_valid;
    logic        data_ready;
    logic [7:0]  data_a;
    logic [19:0] data_b;
    logic        pe_in_valid;
    logic [7:0]  pe_in_a;
    logic [19:0] pe_in_b;
    logic [19:0] pe_in_d;
    logic        pe_in_control_dataflow;
    logic        pe_in_control_propagate;
    logic [4:0]  pe_in_control_shift;
    logic [2:0]  pe_in_id;
    logic        pe_in_last;
    logic        pe_out_valid;
    logic [19:0] pe_out_c;
    logic [2:0]  pe_out_id;
    logic        pe_out_last;
    logic        pe_bad_dataflow;
    logic        resp_valid;
    logic [19:0] resp_c;
    logic [2:0]  resp_id;
    logic        resp_last;
    logic [2:0]  outstanding;
    logic        err_clear;
    logic [2:0]  err_status;

    int errors = 0;
    int checks = 0;

    pe_feed_sequencer #(.LEN_W(8), .MAX_OUT(4)) dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_dataflow            (cmd_dataflow),
        .cmd_shift               (cmd_shift),
        .cmd_id                  (cmd_id),
        .cmd_len                 (cmd_len),
        .cmd_preload             (cmd_preload),
        .cmd_d                   (cmd_d),
        .data_valid              (data_valid),
        .data_ready              (data_ready),
        .data_a                  (data_a),
        .data_b                  (data_b),
        .pe_in_valid             (pe_in_valid),
        .pe_in_a                 (pe_in_a),
        .pe_in_b                 (pe_in_b),
        .pe_in_d                 (pe_in_d),
        .pe_in_control_dataflow  (pe_in_control_dataflow),
        .pe_in_control_propagate (pe_in_control_propagate),
        .pe_in_control_shift     (pe_in_control_shift),
        .pe_in_id                (pe_in_id),
        .pe_in_last              (pe_in_last),
        .pe_out_valid            (pe_out_valid),
        .pe_out_c                (pe_out_c),
        .pe_out_id               (pe_out_id),
        .pe_out_last             (pe_out_last),
        .pe_bad_dataflow         (pe_bad_dataflow),
        .resp_valid              (resp_valid),
        .resp_c                  (resp_c),
        .resp_id                 (resp_id),
        .resp_last               (resp_last),
        .outstanding             (outstanding),
        .err_clear               (err_clear),
        .err_status              (err_status)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cmd(input logic df, input logic [4:0] sh, input logic [2:0] id,
                           input logic [7:0] len, input logic pre, input logic [19:0] d);
        cmd_dataflow = df;
        cmd_shift    = sh;
        cmd_id       = id;
        cmd_len      = len;
        cmd_preload  = pre;
        cmd_d        = d;
    endtask

    // One-beat command without preload; leaves the beat visible on pe_in_*.
    task automatic issue_short(input logic [2:0] id);
        set_cmd(1'b0, 5'd0, id, 8'd1, 1'b0, 20'h0);
        cmd_valid  = 1'b1;
        data_valid = 1'b1;
        data_a     = 8'h5A;
        data_b     = 20'h0005A;
        tick();
        cmd_valid  = 1'b0;
        tick();
        data_valid = 1'b0;
    endtask

    initial begin
        int nbeats;
        int nlast;
        int last_at;

        reset_n = 1'b0;
        cmd_valid = 1'b0; data_valid = 1'b0; data_a = '0; data_b = '0;
        set_cmd(1'b0, 5'd0, 3'd0, 8'd0, 1'b0, 20'h0);
        pe_out_valid = 1'b0; pe_out_c = '0; pe_out_id = '0; pe_out_last = 1'b0;
        pe_bad_dataflow = 1'b0; err_clear = 1'b0;
        tick(); tick();

        check("rst_pe_in_valid", pe_in_valid, 0);
        check("rst_pe_in_d", pe_in_d, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err_status, 0);
        reset_n = 1'b1;
        tick();
        check("rst_cmd_ready", cmd_ready, 1);

        // Command A: WS, shift 3, id 5, len 3, preload 0x00ABC.
        set_cmd(1'b1, 5'd3, 3'd5, 8'd3, 1'b1, 20'h00ABC);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("a_preload_state_no_beat", pe_in_valid, 0);
        check("a_outstanding", outstanding, 1);
        check("a_data_ready_preload", data_ready, 0);
        data_valid = 1'b1; data_a = 8'h11; data_b = 20'h00101;
        tick();
        check("a_pre_valid", pe_in_valid, 1);
        check("a_pre_d", pe_in_d, 20'h00ABC);
        check("a_pre_a", pe_in_a, 0);
        check("a_pre_b", pe_in_b, 0);
        check("a_pre_last", pe_in_last, 0);
        check("a_pre_ctrl", {pe_in_control_dataflow, pe_in_control_propagate,
                             pe_in_control_shift, pe_in_id}, {1'b1, 1'b1, 5'd3, 3'd5});
        check("a_data_ready_compute", data_ready, 1);
        tick();
        check("a_b1", {pe_in_valid, pe_in_a, pe_in_b, pe_in_d, pe_in_last},
              {1'b1, 8'h11, 20'h00101, 20'h0, 1'b0});
        data_a = 8'h22; data_b = 20'h00202;
        tick();
        check("a_b2", {pe_in_valid, pe_in_a, pe_in_b, pe_in_last}, {1'b1, 8'h22, 20'h00202, 1'b0});
        data_a = 8'h33; data_b = 20'h00303;
        tick();
        check("a_b3", {pe_in_valid, pe_in_a, pe_in_b, pe_in_last}, {1'b1, 8'h33, 20'h00303, 1'b1});
        check("a_b3_ctrl", {pe_in_control_propagate, pe_in_id}, {1'b1, 3'd5});
        data_valid = 1'b0;
        check("a_idle_cmd_ready", cmd_ready, 1);
        check("a_idle_data_ready", data_ready, 0);
        tick();
        check("a_after_valid", pe_in_valid, 0);

        // Command B: OS, shift 1, id 6, len 2, no preload; bubble in the data stream.
        set_cmd(1'b0, 5'd1, 3'd6, 8'd2, 1'b0, 20'h0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("b_outstanding", outstanding, 2);
        data_valid = 1'b1; data_a = 8'h44; data_b = 20'h00404;
        tick();
        check("b_b1", {pe_in_valid, pe_in_a, pe_in_last}, {1'b1, 8'h44, 1'b0});
        check("b_b1_ctrl", {pe_in_control_dataflow, pe_in_control_propagate,
                            pe_in_control_shift, pe_in_id}, {1'b0, 1'b0, 5'd1, 3'd6});
        data_valid = 1'b0;
        tick();
        check("b_bubble_valid", pe_in_valid, 0);
        check("b_bubble_hold_a", pe_in_a, 8'h44);
        data_valid = 1'b1; data_a = 8'h55;
        tick();
        check("b_b2", {pe_in_valid, pe_in_a, pe_in_last, pe_in_control_propagate},
              {1'b1, 8'h55, 1'b1, 1'b0});
        data_valid = 1'b0;
        tick();

        // Fill to MAX_OUT.
        issue_short(3'd1);
        issue_short(3'd2);
        check("full_outstanding", outstanding, 4);
        check("full_cmd_ready", cmd_ready, 0);
        set_cmd(1'b0, 5'd0, 3'd3, 8'd1, 1'b0, 20'h0);
        cmd_valid = 1'b1;
        tick();
        check("full_blocked_outstanding", outstanding, 4);
        pe_out_valid = 1'b1; pe_out_last = 1'b1; pe_out_id = 3'd5;
        tick();
        check("dec_outstanding", outstanding, 3);
        check("dec_cmd_ready", cmd_ready, 1);
        check("dec_resp", {resp_valid, resp_last, resp_id}, {1'b1, 1'b1, 3'd5});
        // Accept and last return in the same cycle.
        data_valid = 1'b1;
        tick();
        cmd_valid = 1'b0; pe_out_valid = 1'b0; pe_out_last = 1'b0;
        check("simul_outstanding", outstanding, 3);
        tick();
        data_valid = 1'b0;
        check("simul_beat", {pe_in_valid, pe_in_last, pe_in_id}, {1'b1, 1'b1, 3'd3});
        issue_short(3'd4);
        check("refill_outstanding", outstanding, 4);
        check("refill_cmd_ready", cmd_ready, 0);

        pe_out_valid = 1'b1; pe_out_last = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        pe_out_valid = 1'b0; pe_out_last = 1'b0;
        check("drain_outstanding", outstanding, 0);
        check("drain_err", err_status, 0);
        tick();

        // Zero-length command.
        set_cmd(1'b1, 5'd2, 3'd7, 8'd0, 1'b1, 20'h00777);
        cmd_valid = 1'b1; data_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("zl_err", err_status, 3'b010);
        check("zl_outstanding", outstanding, 0);
        check("zl_cmd_ready", cmd_ready, 1);
        tick();
        data_valid = 1'b0;
        check("zl_no_beat", pe_in_valid, 0);

        // Unexpected last at zero outstanding.
        pe_out_valid = 1'b1; pe_out_last = 1'b1;
        tick();
        pe_out_valid = 1'b0; pe_out_last = 1'b0;
        check("ul_err", err_status, 3'b110);
        check("ul_outstanding", outstanding, 0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clr_err", err_status, 3'b000);

        // Bad dataflow and result forwarding, with err_clear in the same cycle.
        pe_bad_dataflow = 1'b1; err_clear = 1'b1;
        pe_out_valid = 1'b1; pe_out_c = 20'h12345; pe_out_id = 3'd2; pe_out_last = 1'b0;
        tick();
        pe_bad_dataflow = 1'b0; err_clear = 1'b0; pe_out_valid = 1'b0; pe_out_c = '0; pe_out_id = '0;
        check("bd_resp", {resp_valid, resp_c, resp_id, resp_last}, {1'b1, 20'h12345, 3'd2, 1'b0});
        check("bd_err", err_status, 3'b001);
        tick();
        check("bd_resp_drop", resp_valid, 0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // Reset in the middle of a len=4 command after two beats.
        set_cmd(1'b1, 5'd0, 3'd1, 8'd4, 1'b0, 20'h0);
        cmd_valid = 1'b1; data_valid = 1'b1; data_a = 8'h66;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("mid_valid_before", pe_in_valid, 1);
        check("mid_outstanding_before", outstanding, 1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_valid", pe_in_valid, 0);
        check("mid_rst_outstanding", outstanding, 0);
        reset_n = 1'b1;
        tick();
        check("mid_rel_cmd_ready", cmd_ready, 1);
        tick();
        check("mid_no_more_beats", pe_in_valid, 0);
        data_valid = 1'b0;
        issue_short(3'd6);
        check("mid_prop_restart", {pe_in_valid, pe_in_control_propagate}, {1'b1, 1'b1});

        // Longest command: len = 255.
        pe_out_valid = 1'b1; pe_out_last = 1'b1;
        tick();
        pe_out_valid = 1'b0; pe_out_last = 1'b0;
        set_cmd(1'b0, 5'd0, 3'd2, 8'd255, 1'b0, 20'h0);
        cmd_valid = 1'b1; data_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        nbeats = 0; nlast = 0; last_at = 0;
        for (int i = 0; i < 270; i++) begin
            tick();
            if (pe_in_valid) nbeats++;
            if (pe_in_valid && pe_in_last) begin
                nlast++;
                last_at = nbeats;
            end
        end
        data_valid = 1'b0;
        check("long_beats", nbeats, 255);
        check("long_last_count", nlast, 1);
        check("long_last_at", last_at, 255);
        check("long_back_idle", cmd_ready, 1);
        check("long_err", err_status, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
